// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared types, framing constants and parity helper for the multi-lane deserializer
package deser_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } lane_state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    // x is the XOR reduction of the data bits together with the received parity bit
    function automatic logic parity_ok(input parity_mode_t mode, input logic x);
        return (mode == PAR_NONE) || (x == (mode == PAR_ODD));
    endfunction

endpackage

// File: rtl/deserializer_mc_lane.sv
// rtl/deserializer_mc_lane.sv - one serial lane: frame FSM, shift register, parity check, saturating error counter
module deser_lane
    import deser_pkg::*;
#(
    parameter int           TXN_SZ = 8,
    parameter parity_mode_t PARITY = PAR_EVEN,
    parameter int           ERR_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sin,
    input  logic              err_clr,
    output logic              nd,
    output logic [TXN_SZ-1:0] data,
    output logic              parity_err,
    output logic              frame_err,
    output logic [ERR_W-1:0]  err_count
);

    localparam int CW = $clog2(TXN_SZ);

    lane_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TXN_SZ-1:0] shreg_q, shreg_d;
    logic              pbit_q, pbit_d;
    logic [TXN_SZ-1:0] data_q, data_d;
    logic              nd_q, nd_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        pbit_d    = pbit_q;
        data_d    = data_q;
        nd_d      = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        err_cnt_d = err_cnt_q;

        // Counter follows the registered error pulses, so it lags them by one cycle
        if ((perr_q || ferr_q) && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + 1'b1;
        if (err_clr)
            err_cnt_d = '0;

        case (state_q)
            IDLE: begin
                if (sin == START_BIT) begin
                    state_d = DATA;
                    cnt_d   = CW'(TXN_SZ - 1);
                end
            end
            DATA: begin
                shreg_d = {shreg_q[TXN_SZ-2:0], sin};
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0)
                    state_d = (PARITY == PAR_NONE) ? STOP : deser_pkg::PARITY;
            end
            deser_pkg::PARITY: begin
                pbit_d  = sin;
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
                if (sin != STOP_BIT) begin
                    ferr_d = 1'b1;
                end else if (parity_ok(PARITY, ^{shreg_q, pbit_q})) begin
                    data_d = shreg_q;
                    nd_d   = 1'b1;
                end else begin
                    perr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            pbit_q    <= 1'b0;
            data_q    <= '0;
            nd_q      <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            pbit_q    <= pbit_d;
            data_q    <= data_d;
            nd_q      <= nd_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign nd         = nd_q;
    assign data       = data_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign err_count  = err_cnt_q;

endmodule

// File: rtl/deserializer_mc.sv
// rtl/deserializer_mc.sv - NUM_CH independent serial lanes recovering fixed-size frames
module deserializer_mc
    import deser_pkg::*;
#(
    parameter int           TXN_SZ = 8,
    parameter int           NUM_CH = 4,
    parameter parity_mode_t PARITY = PAR_EVEN,
    parameter int           ERR_W  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        sin,
    input  logic                     err_clr,
    output logic [NUM_CH-1:0]        nd,
    output logic [NUM_CH*TXN_SZ-1:0] data,
    output logic [NUM_CH-1:0]        parity_err,
    output logic [NUM_CH-1:0]        frame_err,
    output logic [NUM_CH*ERR_W-1:0]  err_count
);

    // Lane i owns slice [i*TXN_SZ +: TXN_SZ] of data and [i*ERR_W +: ERR_W] of err_count
    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        deser_lane #(
            .TXN_SZ(TXN_SZ),
            .PARITY(PARITY),
            .ERR_W (ERR_W)
        ) u_lane (
            .clock     (clock),
            .reset     (reset),
            .sin       (sin[i]),
            .err_clr   (err_clr),
            .nd        (nd[i]),
            .data      (data[i*TXN_SZ +: TXN_SZ]),
            .parity_err(parity_err[i]),
            .frame_err (frame_err[i]),
            .err_count (err_count[i*ERR_W +: ERR_W])
        );
    end

endmodule

// File: tb/tb_deserializer_mc.sv
// tb/tb_deserializer_mc.sv - table, hand-sequence and randomized model checks for deserializer_mc
module tb_deserializer_mc;
    import deser_pkg::*;

    localparam int NR = 400;

    logic        clock, reset, err_clr;
    logic [1:0]  sin, nd, pe, fe;
    logic [15:0] data;
    logic [3:0]  cnt;
    logic [1:0]  sin_n, nd_n, pe_n, fe_n;
    logic [15:0] data_n;
    logic [3:0]  cnt_n;

    deserializer_mc #(.TXN_SZ(8), .NUM_CH(2), .PARITY(PAR_EVEN), .ERR_W(2)) dut (
        .clock(clock), .reset(reset), .sin(sin), .err_clr(err_clr),
        .nd(nd), .data(data), .parity_err(pe), .frame_err(fe), .err_count(cnt)
    );

    deserializer_mc #(.TXN_SZ(8), .NUM_CH(2), .PARITY(PAR_NONE), .ERR_W(2)) dut_n (
        .clock(clock), .reset(reset), .sin(sin_n), .err_clr(err_clr),
        .nd(nd_n), .data(data_n), .parity_err(pe_n), .frame_err(fe_n), .err_count(cnt_n)
    );

    typedef struct {
        int         ln;
        logic [7:0] d;
        logic       p;
        logic       s;
        logic [2:0] k;
        logic [7:0] xd;
        logic [1:0] xc;
    } vec_t;

    vec_t       tbl [10];
    int         total = 0;
    int         bad = 0;
    int         ev_n [2];
    int         ev_at [2][4];
    logic [2:0] ev_k [2][4];
    logic [7:0] ev_d [2][4];
    logic [1:0] rbits [NR];
    logic [2:0] rk [2][NR];
    logic [7:0] rd [2][NR];
    logic       rclr [NR];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic [1:0] s, input logic [1:0] sn, input logic clr, input logic rst);
        @(posedge clock);
        sin = s; sin_n = sn; err_clr = clr; reset = rst;
        @(negedge clock);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
        return {1'b1, d, p, s};
    endfunction

    task automatic run_bits(input logic [63:0] b0, input logic [63:0] b1, input int n);
        ev_n[0] = 0; ev_n[1] = 0;
        for (int i = 0; i < n; i++) begin
            drive_cycle({b1[n-1-i], b0[n-1-i]}, 2'b00, 1'b0, 1'b0);
            for (int l = 0; l < 2; l++) begin
                if (nd[l] | pe[l] | fe[l]) begin
                    if (ev_n[l] < 4) begin
                        ev_at[l][ev_n[l]] = i;
                        ev_k[l][ev_n[l]]  = {nd[l], pe[l], fe[l]};
                        ev_d[l][ev_n[l]]  = data[l*8 +: 8];
                    end
                    ev_n[l]++;
                end
            end
        end
    endtask

    initial begin
        logic [63:0] b;
        logic [9:0]  fn;
        int          ln, nat, ncnt, pos, badsel;
        logic [7:0]  ndd, rdat;
        logic        rp, rs;
        logic [7:0]  md [2];
        logic [1:0]  mc [2];
        logic        mprev [2];

        tbl[0] = '{0, 8'hA5, 1'b0, 1'b0, 3'b100, 8'hA5, 2'd0};
        tbl[1] = '{0, 8'hA5, 1'b1, 1'b0, 3'b010, 8'hA5, 2'd1};
        tbl[2] = '{1, 8'h3C, 1'b0, 1'b1, 3'b001, 8'h00, 2'd1};
        tbl[3] = '{1, 8'h3C, 1'b0, 1'b0, 3'b100, 8'h3C, 2'd1};
        tbl[4] = '{0, 8'h01, 1'b1, 1'b0, 3'b100, 8'h01, 2'd1};
        tbl[5] = '{0, 8'hFF, 1'b0, 1'b0, 3'b100, 8'hFF, 2'd1};
        tbl[6] = '{0, 8'h01, 1'b0, 1'b0, 3'b010, 8'hFF, 2'd2};
        tbl[7] = '{0, 8'h00, 1'b1, 1'b1, 3'b001, 8'hFF, 2'd3};
        tbl[8] = '{0, 8'h81, 1'b1, 1'b1, 3'b001, 8'hFF, 2'd3};
        tbl[9] = '{0, 8'h00, 1'b0, 1'b0, 3'b100, 8'h00, 2'd3};

        sin = '0; sin_n = '0; err_clr = 1'b0; reset = 1'b1;
        drive_cycle(2'b00, 2'b00, 1'b0, 1'b1);
        drive_cycle(2'b00, 2'b00, 1'b0, 1'b1);
        chk("reset state", {nd, pe, fe, data, cnt}, 64'd0);
        chk("reset state none", {nd_n, pe_n, fe_n, data_n, cnt_n}, 64'd0);

        for (int v = 0; v < 10; v++) begin
            ln = tbl[v].ln;
            b = {52'd0, frame(tbl[v].d, tbl[v].p, tbl[v].s), 1'b0};
            if (ln == 0) run_bits(b, 64'd0, 12);
            else         run_bits(64'd0, b, 12);
            chk($sformatf("vec%0d event", v),
                {8'(ev_n[ln]), 8'(ev_at[ln][0]), ev_k[ln][0], 8'(ev_n[1-ln])},
                {8'd1, 8'd10, tbl[v].k, 8'd0});
            chk($sformatf("vec%0d data_count", v), {data[ln*8 +: 8], cnt[ln*2 +: 2]}, {tbl[v].xd, tbl[v].xc});
        end

        run_bits({42'd0, frame(8'h3C, 1'b0, 1'b0), frame(8'h01, 1'b1, 1'b0)},
                 {42'd0, frame(8'hFF, 1'b0, 1'b0), 11'd0}, 22);
        chk("b2b lane0", {8'(ev_n[0]), 8'(ev_at[0][0]), ev_k[0][0], ev_d[0][0], 8'(ev_at[0][1]), ev_k[0][1], ev_d[0][1]},
            {8'd2, 8'd10, 3'b100, 8'h3C, 8'd21, 3'b100, 8'h01});
        chk("concurrent lane1", {8'(ev_n[1]), 8'(ev_at[1][0]), ev_k[1][0], ev_d[1][0]}, {8'd1, 8'd10, 3'b100, 8'hFF});

        drive_cycle(2'b00, 2'b00, 1'b1, 1'b0);
        chk("clear alone", {28'd0, cnt}, 32'd0);
        for (int j = 0; j < 4; j++) begin
            run_bits({52'd0, frame(8'hA5, 1'b1, 1'b0), 1'b0}, 64'd0, 12);
            chk($sformatf("saturate %0d", j), {ev_k[0][0], cnt[1:0]}, {3'b010, (j < 3) ? 2'(j + 1) : 2'd3});
        end
        run_bits({53'd0, frame(8'hA5, 1'b1, 1'b0)}, 64'd0, 11);
        drive_cycle(2'b00, 2'b00, 1'b1, 1'b0);
        chk("clear wins", {8'(ev_n[0]), ev_k[0][0], cnt[1:0]}, {8'd1, 3'b010, 2'd0});
        drive_cycle(2'b00, 2'b00, 1'b0, 1'b0);
        chk("clear holds", {28'd0, cnt}, 32'd0);

        run_bits({52'd0, frame(8'hA5, 1'b1, 1'b0), 1'b0}, 64'd0, 12);
        run_bits(64'hF, 64'd0, 4);
        drive_cycle(2'b00, 2'b00, 1'b0, 1'b1);
        chk("mid-frame reset", {nd, pe, fe, data, cnt}, 64'd0);
        chk("mid-frame reset none", {nd_n, pe_n, fe_n, data_n, cnt_n}, 64'd0);
        run_bits(64'b0000100, 64'd0, 7);
        chk("no pulse after reset", {8'(ev_n[0]), 8'(ev_n[1])}, 16'd0);
        drive_cycle(2'b00, 2'b00, 1'b0, 1'b1);

        fn = {1'b1, 8'h5A, 1'b0};
        nat = -1; ncnt = 0; ndd = '0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(2'b00, {1'b0, fn[9-i]}, 1'b0, 1'b0);
            if (nd_n[0] | pe_n[0] | fe_n[0] | nd_n[1]) begin
                ncnt++; nat = i; ndd = data_n[7:0];
            end
        end
        chk("par_none frame", {8'(ncnt), 8'(nat), ndd}, {8'd1, 8'd9, 8'h5A});

        for (int c = 0; c < NR; c++) begin
            rbits[c] = 2'b00;
            rclr[c] = ($urandom_range(0, 24) == 0);
            for (int l = 0; l < 2; l++) begin
                rk[l][c] = 3'b000; rd[l][c] = 8'h00;
            end
        end
        for (int l = 0; l < 2; l++) begin
            pos = 0;
            while (1) begin
                pos += $urandom_range(0, 3);
                if (pos + 11 > NR - 2) break;
                rdat = 8'($urandom);
                badsel = $urandom_range(0, 3);
                rp = (^rdat) ^ (badsel == 1);
                rs = (badsel == 2);
                b = {53'd0, frame(rdat, rp, rs)};
                for (int i = 0; i < 11; i++) rbits[pos+i][l] = b[10-i];
                rk[l][pos+10] = rs ? 3'b001 : ((rp != ^rdat) ? 3'b010 : 3'b100);
                rd[l][pos+10] = rdat;
                pos += 11;
            end
        end

        drive_cycle(2'b00, 2'b00, 1'b0, 1'b1);
        for (int l = 0; l < 2; l++) begin
            md[l] = 8'h00; mc[l] = 2'd0; mprev[l] = 1'b0;
        end
        for (int c = 0; c < NR; c++) begin
            drive_cycle(rbits[c], 2'b00, rclr[c], 1'b0);
            for (int l = 0; l < 2; l++) begin
                if (rclr[c]) mc[l] = 2'd0;
                else if (mprev[l] && mc[l] != 2'd3) mc[l] = mc[l] + 2'd1;
                mprev[l] = rk[l][c][1] | rk[l][c][0];
                if (rk[l][c][2]) md[l] = rd[l][c];
                chk($sformatf("rand lane%0d cycle%0d", l, c),
                    {nd[l], pe[l], fe[l], data[l*8 +: 8], cnt[l*2 +: 2]},
                    {rk[l][c], md[l], mc[l]});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deserializer_mc.md
# deserializer_mc

Multi-channel, parametrised successor to the single-lane serial deserializer. It recovers fixed-size frames from `NUM_CH` independent serial lines, with configurable parity mode, and reports parity and framing errors. Each channel keeps a saturating error counter. It sits between the board serial inputs and the command decoders, one lane per upstream link.

## Interface
- `TXN_SZ`, 8: data bits per frame, ≥2.
- `NUM_CH`, 4: number of independent serial lanes, ≥1.
- `PARITY`, `PAR_EVEN`: `PAR_NONE` / `PAR_EVEN` / `PAR_ODD` (`deser_pkg::parity_mode_t`).
- `ERR_W`, 8: width of each per-channel error counter, ≥1.
- `clock`, in, 1: the block's single clock. All registers update on its falling edge; upstream drives `sin` on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `sin`, in, `NUM_CH`: serial input, one bit per lane.
- `err_clr`, in, 1: synchronous clear of all error counters.
- `nd`, out, `NUM_CH`: one-cycle pulse when a lane has a new good frame.
- `data`, out, `NUM_CH`×`TXN_SZ`: last good frame per lane. Held until the next `nd`.
- `parity_err`, out, `NUM_CH`: one-cycle pulse on a parity mismatch.
- `frame_err`, out, `NUM_CH`: one-cycle pulse on a missing stop bit.
- `err_count`, out, `NUM_CH`×`ERR_W`: saturating per-lane error count.

## Operation
- **Frame format:** a start bit `1`, then `TXN_SZ` data bits MSB first, then a parity bit (omitted when `PAR_NONE`), then a stop bit `0`. The line idles at `0`.
- **Lanes:** each lane runs its own FSM with no cross-lane coupling.
- **FSM states:** `IDLE`, `DATA`, `PARITY`, `STOP`.
- `IDLE`:
  - `sin==1` → `DATA`, and `cnt` loads `TXN_SZ-1`.
  - Otherwise the lane stays in `IDLE`.
- `DATA`:
  - Shift `sin` into `shreg` (LSB in), and decrement `cnt`.
  - When `cnt==0` → `PARITY`, or → `STOP` if `PAR_NONE`.
- `PARITY`: capture `sin` as `pbit`, then → `STOP`.
- `STOP`, `sin==0`, frame good:
  - The frame is good if `PAR_NONE`, or if `^{shreg,pbit}` is 0 for even or 1 for odd.
  - Good frame: `data<=shreg`, `nd<=1`.
  - Bad parity: `parity_err<=1` and `data` is unchanged.
  - The lane returns to `IDLE`.
- `STOP`, `sin==1`: `frame_err<=1`, `data` is unchanged, and the lane returns to `IDLE`. The high bit is not treated as a new start bit.
- **Back-to-back frames:** a start bit in the cycle immediately after a stop bit is accepted.
- **Error counters:**
  - Increment by 1 on a `parity_err` or `frame_err` event.
  - Saturate at 2^`ERR_W`−1, with no wrap-around.
  - `err_clr` zeroes every counter. When clear and an increment coincide, the result is 0 (clear wins).

## Timing
- **Reset:**
  - While `reset` is sampled high, all lanes go to `IDLE` and `cnt`, `shreg` and `pbit` clear to 0.
  - `nd`, `parity_err`, `frame_err`, `data` and `err_count` are all 0 in the cycle after that edge.
  - A frame in flight when reset arrives is discarded with no error reported.
  - Reset has priority over `err_clr`.
- **Latency:** a start bit sampled at edge k leads to its `nd` or error pulse at edge k+`TXN_SZ`+2 with parity, or k+`TXN_SZ`+1 with `PAR_NONE`. `data` is valid in the same cycle as `nd`.
- **Pulse width:** `nd`, `parity_err` and `frame_err` are high for exactly one cycle and are mutually exclusive per lane.
- **Counter update:** `err_count` updates on the edge after the error pulse edge, one cycle after the pulse.
- **Throughput:** the minimum frame period is `TXN_SZ`+3 cycles, or +2 with `PAR_NONE`, with no dead cycle.
- **Handshake:** there is no back-pressure. The consumer must take `data` before the next `nd`.

## Structure
- Package `deser_pkg`:
  - `parity_mode_t` enum (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`).
  - `lane_state_t` enum (`IDLE`, `DATA`, `PARITY`, `STOP`).
  - `START_BIT = 1'b1`, `STOP_BIT = 1'b0`.
- Sub-module `deser_lane`:
  - Holds one lane's FSM, shift register, parity check and error counter.
  - Takes parameters `TXN_SZ`, `PARITY` and `ERR_W`.
  - `deserializer_mc` is a generate loop of `NUM_CH` instances.

## Test plan
All scenarios use `TXN_SZ=8`, `NUM_CH=2`, `PAR_EVEN` and `ERR_W=2` unless stated otherwise.

1. **Good frame:** lane 0 receives `1`, `10100101`, `0`, `0`. Required: `nd[0]` pulses at edge k+10, `data[0]=8'hA5`, and lane 1 stays quiet.
2. **Parity error:** lane 0 receives 0xA5 with parity bit `1`. Required: `parity_err[0]` pulse and no `nd`; `data[0]` keeps its old value and `err_count[0]=1`.
3. **Framing error:** lane 1 receives 0x3C, parity `0`, stop `1`. Required: one `frame_err[1]` pulse and no `nd`; the lane returns to `IDLE` and the next valid frame decodes correctly.
4. **Back-to-back and concurrent:**
   - Lane 0 receives 0x3C (parity 0) followed immediately by 0x01 (parity 1).
   - Lane 1 receives 0xFF concurrently.
   - Required: lane 0 `nd` pulses 11 cycles apart with data 0x3C then 0x01, and lane 1 gives `nd` with 0xFF.
5. **Counter saturation and clear:**
   - Four parity errors on lane 0 → `err_count[0]=3`.
   - `err_clr` asserted in the same cycle as a fifth error's increment → 0.
6. **Reset and `PAR_NONE`:**
   - Reset asserted 4 bits into a frame: all outputs are 0 the next cycle, and the remaining bits produce no pulse until a new start bit.
   - With `PAR_NONE`, 0x5A decodes with `nd` at edge k+9.
